// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO and a valid/ready write port.
// Defining UART_TX_PARITY_EN adds an even-parity bit between the data and stop bits.
module uart_transmitter #(
    parameter int CLOCK_DIVIDER = 104,
    parameter int FIFO_DEPTH    = 4,
    parameter int STOP_BITS     = 1
) (
    input  logic                          clock_12mhz,
    input  logic                          reset,
    input  logic [7:0]                    data,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLOCK_DIVIDER);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCK_DIVIDER - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state_reg, state_next;
    logic [BAUD_W-1:0]   baud_reg, baud_next;
    logic [2:0]          bit_cnt_reg, bit_cnt_next;
    logic [8:0]          shift_reg, shift_next;
    logic                tx_reg, tx_next;
    logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]    level_reg, level_next;
    logic [7:0]          fifo_mem [FIFO_DEPTH];

    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                baud_end;
    logic [7:0]          head;
    logic                frame_bit8;

    assign data_ready = (level_reg != LVL_FULL);
    assign push       = data_valid && data_ready;
    assign fifo_empty = (level_reg == '0);
    assign baud_end   = (baud_reg == BAUD_LAST);
    assign head       = fifo_mem[rd_ptr_reg];

    // Bit 8 of the shift register is what follows data bit 7: parity, or the stop level.
`ifdef UART_TX_PARITY_EN
    assign frame_bit8 = ^head;
`else
    assign frame_bit8 = 1'b1;
`endif

    always_ff @(posedge clock_12mhz) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= data;
        end
    end

    always_ff @(posedge clock_12mhz or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '1;
            tx_reg      <= 1'b1;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            level_reg   <= level_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = {frame_bit8, head};
                    tx_next    = 1'b0;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_next    = '0;
                    bit_cnt_next = '0;
                    tx_next      = shift_reg[0];
                    shift_next   = {1'b1, shift_reg[8:1]};
                    state_next   = DATA;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next  = '0;
                    tx_next    = shift_reg[0];
                    shift_next = {1'b1, shift_reg[8:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_next  = '0;
                    tx_next    = 1'b1;
                    state_next = STOP;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_cnt_reg == STOP_LAST) begin
                        bit_cnt_next = '0;
                        // Chain straight into the next start bit so queued frames are gapless.
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            shift_next = {frame_bit8, head};
                            tx_next    = 1'b0;
                            state_next = START;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    assign wr_ptr_next = wr_ptr_reg + PTR_W'(push);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    assign level_next  = level_reg + LVL_W'(push) - LVL_W'(pop);

    assign uart_tx    = tx_reg;
    assign fifo_level = level_reg;
    assign busy       = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter at default parameters.
// Frame timing follows UART_TX_PARITY_EN when it is defined for the build.
module tb_uart_transmitter;

    localparam int CD = 104;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CD;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_level;

    int cyc = 0;
    int n_asserts = 0;
    int n_fail = 0;
    int wr_edge = 0;
    int e1 = 0;
    int f0 = 0;
    logic [7:0] seq [6];

    uart_transmitter dut (
        .clock_12mhz (clk),
        .reset       (reset),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_to_edge(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data       = b;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        wr_edge    = cyc;
    endtask

    // Single byte into an idle transmitter: latency, bit pattern, and end of busy.
    task automatic send_and_check(input logic [7:0] b);
        int n;
        send_byte(b);
        n = wr_edge;
        @(negedge clk);
        check("tx_before_start", uart_tx, 1'b1);
        check("level_after_write", fifo_level, 3'd1);
        check("busy_after_write", busy, 1'b1);
        wait_to_edge(n + 1);
        check("tx_start_fall", uart_tx, 1'b0);
        check("level_after_pop", fifo_level, 3'd0);
        for (int bi = 0; bi < NB; bi++) begin
            wait_to_edge(n + 1 + CD * bi + CD / 2);
            check("frame_bit", uart_tx, exp_bit(b, bi));
        end
        wait_to_edge(n + FRAME);
        check("busy_last_cycle", busy, 1'b1);
        wait_to_edge(n + FRAME + 1);
        check("busy_drop", busy, 1'b0);
        check("tx_idle_after", uart_tx, 1'b1);
        $display("byte %02h sent at edge %0d checked", b, n);
    endtask

    initial begin
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h55;
        seq[3] = 8'h3C; seq[4] = 8'h81; seq[5] = 8'h77;
        reset      = 1'b0;
        data       = 8'h00;
        data_valid = 1'b0;

        // Reset state, then a long quiet period
        repeat (3) @(negedge clk);
        check("rst_tx", uart_tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", data_ready, 1'b1);
        check("rst_level", fifo_level, 3'd0);
        reset = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            check("quiet_tx", uart_tx, 1'b1);
            check("quiet_busy", busy, 1'b0);
            check("quiet_ready", data_ready, 1'b1);
            check("quiet_level", fifo_level, 3'd0);
        end
        $display("quiet period after reset checked");

        send_and_check(8'hA5);
        send_and_check(8'h07);

        // Back-to-back burst with data_valid held high
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            data       = seq[i];
            data_valid = 1'b1;
            check("ready_before_push", data_ready, 1'b1);
            @(posedge clk);
            @(negedge clk);
            if (i == 0) e1 = cyc;
        end
        check("burst_level_full", fifo_level, 3'd4);
        check("burst_ready_low", data_ready, 1'b0);
        data = seq[5];
        for (int bi = 0; bi < NB; bi++) begin
            wait_to_edge(e1 + 1 + CD * bi + CD / 2);
            check("burst_frame0_bit", uart_tx, exp_bit(seq[0], bi));
        end
        wait_to_edge(e1 + FRAME);
        check("full_level_hold", fifo_level, 3'd4);
        check("full_ready_hold", data_ready, 1'b0);
        wait_to_edge(e1 + FRAME + 1);
        check("pop_no_push_level", fifo_level, 3'd3);
        check("pop_no_push_ready", data_ready, 1'b1);
        check("gapless_start", uart_tx, 1'b0);
        wait_to_edge(e1 + FRAME + 2);
        check("late_push_level", fifo_level, 3'd4);
        check("late_push_ready", data_ready, 1'b0);
        data_valid = 1'b0;
        for (int k = 1; k < 6; k++) begin
            for (int bi = 0; bi < NB; bi++) begin
                wait_to_edge(e1 + 1 + FRAME * k + CD * bi + CD / 2);
                check("burst_frame_bit", uart_tx, exp_bit(seq[k], bi));
            end
            $display("burst frame %0d byte %02h checked", k, seq[k]);
        end
        wait_to_edge(e1 + 1 + 6 * FRAME);
        check("burst_done_busy", busy, 1'b0);
        check("burst_done_level", fifo_level, 3'd0);

        // Reset in the middle of a frame with two bytes queued
        send_byte(8'hC3);
        f0 = wr_edge;
        @(negedge clk);
        data       = 8'h11;
        data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data = 8'h22;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        wait_to_edge(f0 + 1 + CD * 3 + CD / 2);
        check("pre_reset_tx", uart_tx, 1'b0);
        check("pre_reset_level", fifo_level, 3'd2);
        check("pre_reset_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("async_rst_tx", uart_tx, 1'b1);
        check("async_rst_level", fifo_level, 3'd0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ready", data_ready, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            check("post_rst_tx", uart_tx, 1'b1);
            check("post_rst_busy", busy, 1'b0);
        end
        $display("mid-frame reset checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
